// File: rtl/puzzle_pkg.sv
// Shared definitions for the puzzle datapath: board geometry defaults,
// level-checker state codes and the debug code for an illegal state.
package puzzle_pkg;

  localparam int LINHAS_PADRAO   = 8;
  localparam int COLUNAS_PADRAO  = 8;
  localparam int LARG_CEL_PADRAO = 1;

  localparam logic [2:0] OCIOSO    = 3'd0;
  localparam logic [2:0] VARRE     = 3'd1;
  localparam logic [2:0] DRENA     = 3'd2;
  localparam logic [2:0] CONCLUIDO = 3'd3;
  localparam logic [2:0] ESPERA    = 3'd4;

  localparam logic [2:0] DB_ERRO = 3'd7;

  function automatic logic em_varredura(input logic [2:0] estado);
    return (estado == VARRE) || (estado == DRENA);
  endfunction

endpackage

// File: rtl/verificador_nivel_contador_endereco.sv
// Linear cell-address counter: clears on zera, advances on conta and
// saturates at the last cell so the shared read address never wraps.
module contador_endereco #(
  parameter int CELULAS = 64
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         i_zera,
  input  logic                         i_conta,
  output logic [$clog2(CELULAS)-1:0]   o_endereco,
  output logic                         o_fim
);

  localparam int LARG_END = $clog2(CELULAS);
  localparam logic [LARG_END-1:0] ULTIMO = LARG_END'(CELULAS - 1);

  logic [LARG_END-1:0] r_endereco;

  always_ff @(posedge clock) begin
    if (reset || i_zera) begin
      r_endereco <= '0;
    end else if (i_conta && (r_endereco != ULTIMO)) begin
      r_endereco <= r_endereco + LARG_END'(1);
    end
  end

  assign o_endereco = r_endereco;
  assign o_fim      = (r_endereco == ULTIMO);

endmodule

// File: rtl/verificador_nivel.sv
// Scans the board against the level solution after each accepted move and
// emits a one-cycle nivel_concluido pulse when every cell matches.
module verificador_nivel
  import puzzle_pkg::*;
#(
  parameter int LINHAS   = LINHAS_PADRAO,
  parameter int COLUNAS  = COLUNAS_PADRAO,
  parameter int LARG_CEL = LARG_CEL_PADRAO
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                habilita,
  input  logic                                jogada,
  input  logic [LARG_CEL-1:0]                 celula_tabuleiro,
  input  logic [LARG_CEL-1:0]                 celula_gabarito,
  output logic [$clog2(LINHAS*COLUNAS)-1:0]   end_celula,
  output logic                                nivel_concluido,
  output logic                                ocupado,
  output logic [2:0]                          db_estado
);

  localparam int CELULAS  = LINHAS * COLUNAS;
  localparam int LARG_END = $clog2(CELULAS);
  localparam logic [LARG_END-1:0] PENULTIMO = LARG_END'(CELULAS - 2);

  logic [2:0] r_estado;
  logic       r_pendente;
  logic       r_emitido;
  logic       r_cmp_valido;

  logic [2:0]          w_estado_next;
  logic                w_pendente_next;
  logic                w_inicia;
  logic                w_conta;
  logic                w_termina;
  logic                w_sucesso;
  logic                w_pend_efetivo;
  logic                w_igual;
  logic                w_erro;
  logic                w_zera;
  logic                w_penultimo;
  logic                w_fim;
  logic [LARG_END-1:0] w_endereco;

  contador_endereco #(
    .CELULAS (CELULAS)
  ) u_contador (
    .clock      (clock),
    .reset      (reset),
    .i_zera     (w_zera),
    .i_conta    (w_conta),
    .o_endereco (w_endereco),
    .o_fim      (w_fim)
  );

  // r_emitido: the address on the bus this cycle belongs to the scan.
  // r_cmp_valido: the read data arriving this cycle must be compared.
  assign w_igual        = (celula_tabuleiro == celula_gabarito);
  assign w_erro         = r_cmp_valido && !w_igual;
  assign w_penultimo    = (w_endereco == PENULTIMO);
  assign w_pend_efetivo = r_pendente || jogada;

  always_comb begin
    w_estado_next   = r_estado;
    w_pendente_next = r_pendente;
    w_inicia        = 1'b0;
    w_conta         = 1'b0;
    w_termina       = 1'b0;
    w_sucesso       = 1'b0;

    case (r_estado)
      OCIOSO: begin
        w_pendente_next = 1'b0;
        if (habilita && jogada) begin
          w_estado_next = VARRE;
          w_inicia      = 1'b1;
        end
      end
      VARRE: begin
        if (!habilita) begin
          w_estado_next   = OCIOSO;
          w_pendente_next = 1'b0;
        end else if (w_erro) begin
          w_termina = 1'b1;
        end else begin
          w_conta         = 1'b1;
          w_pendente_next = w_pend_efetivo;
          if (w_penultimo || w_fim) begin
            w_estado_next = DRENA;
          end
        end
      end
      DRENA: begin
        if (!habilita) begin
          w_estado_next   = OCIOSO;
          w_pendente_next = 1'b0;
        end else if (w_erro) begin
          w_termina = 1'b1;
        end else if (r_cmp_valido && !r_emitido) begin
          w_termina = 1'b1;
          w_sucesso = 1'b1;
        end else begin
          w_pendente_next = w_pend_efetivo;
        end
      end
      CONCLUIDO: begin
        w_estado_next   = ESPERA;
        w_pendente_next = 1'b0;
      end
      ESPERA: begin
        w_pendente_next = 1'b0;
        if (!habilita) begin
          w_estado_next = OCIOSO;
        end
      end
      default: begin
        w_estado_next   = OCIOSO;
        w_pendente_next = 1'b0;
      end
    endcase

    // A move that arrived during the scan supersedes its verdict.
    if (w_termina) begin
      w_pendente_next = 1'b0;
      if (w_pend_efetivo) begin
        w_estado_next = VARRE;
        w_inicia      = 1'b1;
      end else if (w_sucesso) begin
        w_estado_next = CONCLUIDO;
      end else begin
        w_estado_next = OCIOSO;
      end
    end
  end

  assign w_zera = w_inicia || !em_varredura(w_estado_next);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado     <= OCIOSO;
      r_pendente   <= 1'b0;
      r_emitido    <= 1'b0;
      r_cmp_valido <= 1'b0;
    end else begin
      r_estado     <= w_estado_next;
      r_pendente   <= w_pendente_next;
      r_emitido    <= w_inicia || w_conta;
      r_cmp_valido <= r_emitido && em_varredura(w_estado_next) && !w_inicia;
    end
  end

  assign end_celula      = w_endereco;
  assign ocupado         = em_varredura(r_estado);
  assign nivel_concluido = (r_estado == CONCLUIDO);

  always_comb begin
    case (r_estado)
      OCIOSO:    db_estado = 3'd0;
      VARRE:     db_estado = 3'd1;
      DRENA:     db_estado = 3'd2;
      CONCLUIDO: db_estado = 3'd3;
      ESPERA:    db_estado = 3'd4;
      default:   db_estado = DB_ERRO;
    endcase
  end

endmodule

// File: tb/tb_verificador_nivel.sv
// Bench for verificador_nivel: board/solution memory models, table of scan
// scenarios with timed checkpoints, and a pulse scoreboard.
module tb_verificador_nivel;

  localparam int CELULAS = 64;
  localparam int LIMITE  = 140;

  logic       clk = 1'b0;
  logic       reset;
  logic       habilita;
  logic       jogada;
  logic       cel_tab;
  logic       cel_gab;
  logic [5:0] end_celula;
  logic       nivel_concluido;
  logic       ocupado;
  logic [2:0] db_estado;

  logic mem_tab [CELULAS];
  logic mem_gab [CELULAS];

  int cyc    = 0;
  int testes = 0;
  int falhas = 0;
  int sb[$];

  typedef struct {
    int dif;
    int jog2;
    int hab;
    int rst;
    int pulso;
    int c1; int e1; int a1; int o1;
    int c2; int e2; int a2; int o2;
    int c3; int e3; int a3; int o3;
  } vetor_t;

  vetor_t tabela [9];

  always #5 clk = ~clk;

  verificador_nivel dut (
    .clock            (clk),
    .reset            (reset),
    .habilita         (habilita),
    .jogada           (jogada),
    .celula_tabuleiro (cel_tab),
    .celula_gabarito  (cel_gab),
    .end_celula       (end_celula),
    .nivel_concluido  (nivel_concluido),
    .ocupado          (ocupado),
    .db_estado        (db_estado)
  );

  always @(posedge clk) begin
    cel_tab <= mem_tab[end_celula];
    cel_gab <= mem_gab[end_celula];
    cyc     <= cyc + 1;
  end

  task automatic checa(input string nome, input int obtido, input int esperado);
    testes++;
    if (obtido != esperado) begin
      falhas++;
      $display("FAIL %s: obtido %0d, esperado %0d", nome, obtido, esperado);
    end
  endtask

  // Each pulse must match the next expected edge in the scoreboard.
  always @(negedge clk) begin
    if (nivel_concluido) begin
      if (sb.size() == 0) begin
        checa("pulso_inesperado", cyc, -1);
      end else begin
        checa("instante_pulso", cyc, sb.pop_front());
      end
      $display("[TB] pulso nivel_concluido na borda %0d", cyc);
    end
  end

  task automatic preparar(input int dif);
    for (int i = 0; i < CELULAS; i++) begin
      mem_gab[i] = 1'($urandom);
      mem_tab[i] = mem_gab[i];
    end
    if (dif >= 0) mem_tab[dif] = ~mem_gab[dif];
  endtask

  task automatic ponto(input int v, input int k, input int est, input int ende, input int ocu);
    checa($sformatf("v%0d_k%0d_estado", v, k), int'(db_estado), est);
    checa($sformatf("v%0d_k%0d_end", v, k), int'(end_celula), ende);
    checa($sformatf("v%0d_k%0d_ocupado", v, k), int'(ocupado), ocu);
  endtask

  task automatic rodar(input int v);
    vetor_t t;
    int e0;
    t = tabela[v];
    preparar(t.dif);
    habilita = 1'b1;
    reset    = 1'b0;
    @(negedge clk);
    jogada = 1'b1;
    e0 = cyc + 1;
    if (t.pulso >= 0) sb.push_back(e0 + t.pulso);
    for (int k = 0; k <= LIMITE; k++) begin
      @(negedge clk);
      if (k == t.c1) ponto(v, k, t.e1, t.a1, t.o1);
      if (k == t.c2) ponto(v, k, t.e2, t.a2, t.o2);
      if (k == t.c3) ponto(v, k, t.e3, t.a3, t.o3);
      jogada = (k + 1 == t.jog2);
      if (k + 1 == t.hab) habilita = 1'b0;
      reset = (k + 1 == t.rst);
    end
    habilita = 1'b0;
    jogada   = 1'b0;
    reset    = 1'b0;
    repeat (2) @(negedge clk);
    checa($sformatf("v%0d_estado_final", v), int'(db_estado), 0);
    checa($sformatf("v%0d_pulso_ausente", v), sb.size(), 0);
    sb.delete();
    $display("[TB] vetor %0d concluido: dif=%0d jog2=%0d hab=%0d rst=%0d pulso=%0d",
             v, t.dif, t.jog2, t.hab, t.rst, t.pulso);
  endtask

  initial begin
    int e0;
    reset    = 1'b1;
    habilita = 1'b0;
    jogada   = 1'b0;
    preparar(-1);
    repeat (3) @(negedge clk);
    checa("reset_end", int'(end_celula), 0);
    checa("reset_pulso", int'(nivel_concluido), 0);
    checa("reset_ocupado", int'(ocupado), 0);
    checa("reset_estado", int'(db_estado), 0);
    reset = 1'b0;

    // A move while disabled is ignored.
    jogada = 1'b1;
    @(negedge clk);
    jogada = 1'b0;
    @(negedge clk);
    checa("jogada_sem_habilita_estado", int'(db_estado), 0);
    checa("jogada_sem_habilita_ocupado", int'(ocupado), 0);
    $display("[TB] jogada com habilita=0 aplicada");

    tabela[0] = '{-1, -1, -1, -1,  65,  10, 1, 10, 1,  64, 2, 63, 1,  66, 4, 0, 0};
    tabela[1] = '{10, -1, -1, -1,  -1,  11, 1, 11, 1,  12, 0,  0, 0,  70, 0, 0, 0};
    tabela[2] = '{-1, 30, -1, -1, 130,  64, 2, 63, 1,  65, 1,  0, 1,  66, 1, 1, 1};
    tabela[3] = '{-1, 30, 20, -1,  -1,  19, 1, 19, 1,  20, 0,  0, 0,  31, 0, 0, 0};
    tabela[4] = '{-1, -1, -1, 40,  -1,  39, 1, 39, 1,  40, 0,  0, 0, 100, 0, 0, 0};
    tabela[5] = '{63, -1, -1, -1,  -1,  64, 2, 63, 1,  65, 0,  0, 0,  66, 0, 0, 0};
    tabela[6] = '{ 0, -1, -1, -1,  -1,   1, 1,  1, 1,   2, 0,  0, 0,   3, 0, 0, 0};
    tabela[7] = '{10, 12, -1, -1,  -1,  12, 1,  0, 1,  23, 1, 11, 1,  24, 0, 0, 0};
    tabela[8] = '{-1, 65, -1, -1, 130,  65, 1,  0, 1, 130, 3,  0, 0, 131, 4, 0, 0};

    for (int v = 0; v < 9; v++) begin
      rodar(v);
    end

    // Repeated moves while waiting must not retrigger the pulse.
    preparar(-1);
    habilita = 1'b1;
    @(negedge clk);
    jogada = 1'b1;
    e0 = cyc + 1;
    sb.push_back(e0 + 65);
    for (int k = 0; k <= 66; k++) begin
      @(negedge clk);
      jogada = 1'b0;
    end
    for (int i = 0; i < 200; i++) begin
      jogada = 1'b1;
      @(negedge clk);
      checa($sformatf("espera_estado_%0d", i), int'(db_estado), 4);
    end
    jogada   = 1'b0;
    habilita = 1'b0;
    @(negedge clk);
    checa("espera_saida_estado", int'(db_estado), 0);
    checa("espera_pulso_ausente", sb.size(), 0);
    $display("[TB] sequencia ESPERA com 200 jogadas aplicada");

    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

  initial begin
    #200000;
    falhas++;
    $display("FAIL watchdog: obtido tempo %0t, esperado fim antes", $time);
    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

endmodule
